// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake bundle between fetch_unit, instruction memory, transfer stage and decode.
// master (fetch side): in redirect/redirect_pc/halt/imem_rvalid/imem_rdata/ir_ready, out imem_req/imem_addr/ir_valid/ir/ir_pc
// slave (environment side): the same signals with directions reversed
interface fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;
    modport master(
        input  redirect, redirect_pc, halt, imem_rvalid, imem_rdata, ir_ready,
        output imem_req, imem_addr, ir_valid, ir, ir_pc
    );
    modport slave(
        output redirect, redirect_pc, halt, imem_rvalid, imem_rdata, ir_ready,
        input  imem_req, imem_addr, ir_valid, ir, ir_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC holder issuing one imem read at a time and presenting instructions to decode.
// clk, rst_n (sync active-low); bus: fetch_unit_if.master; stall_cycles only with FETCH_STALL_COUNT_EN
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);
    typedef enum logic [1:0] {FETCH, WAIT, FULL, DROP} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        req;
    assign req           = rst_n && state_q == FETCH && !bus.halt && !bus.redirect;
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.ir        = ir_q;
    assign bus.ir_pc     = ir_pc_q;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            ir_valid_d = 1'b0;
            // an outstanding read must still be drained before the next request
            state_d    = ((state_q == WAIT || state_q == DROP) && !bus.imem_rvalid) ? DROP : FETCH;
        end else begin
            case (state_q)
                FETCH: state_d = req ? WAIT : FETCH;
                WAIT: if (bus.imem_rvalid) begin
                    ir_d       = bus.imem_rdata;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + PC_STEP;
                    state_d    = FULL;
                end
                FULL: if (bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end
                DROP: state_d = bus.imem_rvalid ? FETCH : DROP;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_q;
    assign stall_cycles = stall_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= '0;
        else if (!ir_valid_q && !bus.halt && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a latency-configurable memory model.
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;
    int          lat;
    logic [31:0] mem_a;
    fetch_unit_if f();
`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall;
    fetch_unit dut(.clk(clk), .rst_n(rst_n), .bus(f), .stall_cycles(stall));
`else
    fetch_unit dut(.clk(clk), .rst_n(rst_n), .bus(f));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory answers each request lat cycles later with addr ^ DEAD_0000
    initial begin
        f.imem_rvalid = 1'b0;
        f.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (f.imem_req === 1'b1) begin
                mem_a = f.imem_addr;
                repeat (lat) @(posedge clk);
                #1 f.imem_rvalid = 1'b1;
                f.imem_rdata = mem_a ^ 32'hDEAD_0000;
                @(posedge clk);
                #1 f.imem_rvalid = 1'b0;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // settle to FULL/idle, hold reset two edges, release so the current cycle is cycle 0
    task automatic reset_dut;
        f.ir_ready = 1'b0;
        f.redirect = 1'b0;
        f.halt     = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", f.imem_req); end
        step();
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ir_valid got %b exp 0", f.ir_valid); end
        checks++; if (f.ir !== 32'h0) begin errors++; $display("FAIL rst_ir got %h exp 0", f.ir); end
        checks++; if (f.ir_pc !== 32'h0) begin errors++; $display("FAIL rst_ir_pc got %h exp 0", f.ir_pc); end
        checks++; if (f.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", f.imem_addr); end
    endtask

    task automatic test_sequential;
        lat = 1;
        reset_dut();
        f.ir_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (f.imem_req !== 1'b1 || f.imem_addr !== k) begin errors++; $display("FAIL seq_req k=%0d got req %b addr %h exp 1 %h", k, f.imem_req, f.imem_addr, k); end
            @(negedge clk);
            checks++; if (f.imem_req !== 1'b0 || f.ir_valid !== 1'b0) begin errors++; $display("FAIL seq_wait k=%0d got req %b vld %b exp 0 0", k, f.imem_req, f.ir_valid); end
            @(negedge clk);
            checks++; if (f.ir_valid !== 1'b1 || f.ir !== (32'hDEAD_0000 | k) || f.ir_pc !== k) begin errors++; $display("FAIL seq_ir k=%0d got vld %b ir %h pc %h exp 1 %h %h", k, f.ir_valid, f.ir, f.ir_pc, 32'hDEAD_0000 | k, k); end
        end
        step();
        f.ir_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        lat = 1;
        reset_dut();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (f.ir_valid !== 1'b1 || f.ir !== 32'hDEAD_0000 || f.ir_pc !== 32'h0 || f.imem_req !== 1'b0) begin errors++; $display("FAIL bp_hold i=%0d got vld %b ir %h pc %h req %b exp 1 dead0000 0 0", i, f.ir_valid, f.ir, f.ir_pc, f.imem_req); end
        end
        step();
        f.ir_ready = 1'b1;
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b1 || f.imem_req !== 1'b0) begin errors++; $display("FAIL bp_accept got vld %b req %b exp 1 0", f.ir_valid, f.imem_req); end
        step();
        f.ir_ready = 1'b0;
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b1 || f.imem_addr !== 32'h1 || f.ir_valid !== 1'b0) begin errors++; $display("FAIL bp_next got req %b addr %h vld %b exp 1 1 0", f.imem_req, f.imem_addr, f.ir_valid); end
    endtask

    task automatic test_redirect_wait;
        lat = 2;
        reset_dut();
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b1 || f.imem_addr !== 32'h0) begin errors++; $display("FAIL rw_req0 got req %b addr %h exp 1 0", f.imem_req, f.imem_addr); end
        step();
        f.redirect    = 1'b1;
        f.redirect_pc = 32'h40;
        step();
        f.redirect = 1'b0;
        @(negedge clk);
        checks++; if (f.imem_addr !== 32'h40 || f.imem_req !== 1'b0 || f.imem_rvalid !== 1'b1) begin errors++; $display("FAIL rw_drop got addr %h req %b rvalid %b exp 40 0 1", f.imem_addr, f.imem_req, f.imem_rvalid); end
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b1 || f.imem_addr !== 32'h40) begin errors++; $display("FAIL rw_req1 got req %b addr %h exp 1 40", f.imem_req, f.imem_addr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (f.ir_valid !== 1'b0) begin errors++; $display("FAIL rw_novalid i=%0d got %b exp 0", i, f.ir_valid); end
        end
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b1 || f.ir !== 32'hDEAD_0040 || f.ir_pc !== 32'h40) begin errors++; $display("FAIL rw_ir got vld %b ir %h pc %h exp 1 dead0040 40", f.ir_valid, f.ir, f.ir_pc); end
    endtask

    task automatic test_redirect_full;
        lat = 1;
        reset_dut();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b1 || f.ir_pc !== 32'h0) begin errors++; $display("FAIL rf_full got vld %b pc %h exp 1 0", f.ir_valid, f.ir_pc); end
        step();
        f.redirect    = 1'b1;
        f.redirect_pc = 32'h80;
        f.ir_ready    = 1'b1;
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b0) begin errors++; $display("FAIL rf_noreq got %b exp 0", f.imem_req); end
        step();
        f.redirect = 1'b0;
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b0 || f.imem_req !== 1'b1 || f.imem_addr !== 32'h80) begin errors++; $display("FAIL rf_kill got vld %b req %b addr %h exp 0 1 80", f.ir_valid, f.imem_req, f.imem_addr); end
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b0) begin errors++; $display("FAIL rf_wait got vld %b exp 0", f.ir_valid); end
        step();
        f.ir_ready = 1'b0;
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b1 || f.ir !== 32'hDEAD_0080 || f.ir_pc !== 32'h80) begin errors++; $display("FAIL rf_ir got vld %b ir %h pc %h exp 1 dead0080 80", f.ir_valid, f.ir, f.ir_pc); end
    endtask

    task automatic test_wrap;
        lat = 1;
        reset_dut();
        f.redirect    = 1'b1;
        f.redirect_pc = 32'hFFFF_FFFF;
        f.ir_ready    = 1'b1;
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_redir_req got %b exp 0", f.imem_req); end
        step();
        f.redirect = 1'b0;
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b1 || f.imem_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_req got req %b addr %h exp 1 ffffffff", f.imem_req, f.imem_addr); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b1 || f.ir !== 32'h2152_FFFF || f.ir_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_ir got vld %b ir %h pc %h exp 1 2152ffff ffffffff", f.ir_valid, f.ir, f.ir_pc); end
        step();
        f.ir_ready = 1'b0;
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b1 || f.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got req %b addr %h exp 1 0", f.imem_req, f.imem_addr); end
    endtask

    task automatic test_halt;
        lat = 1;
        reset_dut();
        f.halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (f.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req i=%0d got %b exp 0", i, f.imem_req); end
        end
        step();
        f.halt = 1'b0;
        @(negedge clk);
        checks++; if (f.imem_req !== 1'b1 || f.imem_addr !== 32'h0) begin errors++; $display("FAIL halt_release got req %b addr %h exp 1 0", f.imem_req, f.imem_addr); end
        step();
        f.halt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b1 || f.ir !== 32'hDEAD_0000) begin errors++; $display("FAIL halt_wait got vld %b ir %h exp 1 dead0000", f.ir_valid, f.ir); end
        f.halt = 1'b0;
    endtask

`ifdef FETCH_STALL_COUNT_EN
    task automatic test_stall_count;
        lat = 1;
        reset_dut();
        @(negedge clk);
        checks++; if (stall !== 32'd0) begin errors++; $display("FAIL stall_c0 got %0d exp 0", stall); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (f.ir_valid !== 1'b1 || stall !== 32'd2) begin errors++; $display("FAIL stall_first got vld %b cnt %0d exp 1 2", f.ir_valid, stall); end
        step();
        force dut.stall_q = 32'hFFFF_FFFF;
        step();
        release dut.stall_q;
        f.ir_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++; if (stall !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stall_sat got %h exp ffffffff", stall); end
        f.ir_ready = 1'b0;
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        lat           = 1;
        rst_n         = 1'b0;
        f.redirect    = 1'b0;
        f.redirect_pc = '0;
        f.halt        = 1'b0;
        f.ir_ready    = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_full();
        test_reset();
        test_wrap();
        test_halt();
`ifdef FETCH_STALL_COUNT_EN
        test_stall_count();
`endif
        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
